count_pwm_stage: RTL and testbench
==================================

Name: count_pwm_stage

Overview:
- Downstream consumer of the 5-bit synchronous up-counter value (q).
- Turns the free-running count into a registered PWM output, using a duty value loaded over a valid/ready handshake.
- New duty values are double-buffered and take effect only at a counter wrap, so the output never glitches mid-period.
- Also flags each wrap and keeps a saturating period tally for the next stage.

Parameters:
- CW, 5, counter/duty width; one period = 2**CW counts.
- PW, 8, width of the saturating period tally.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- q_in  in  CW  count value from the upstream sync reset counter.
- duty_in  in  CW  requested duty, in counts per period.
- duty_valid  in  1  duty_in is valid this cycle.
- duty_ready  out  1  stage can accept a new duty value.
- tally_clr  in  1  synchronous clear of period_tally.
- pwm_out  out  1  registered PWM output.
- wrap_pulse  out  1  one-cycle pulse per detected wrap.
- period_tally  out  PW  wraps seen since reset/clear; saturates at 2**PW-1.

Behaviour:
Reset values:
- pwm_out=0, wrap_pulse=0, period_tally=0, duty_ready=1.
- Active duty=0, pending duty=0, q_prev=0, prev_ok=0.
- Handshake FSM starts in IDLE.

Wrap detection:
- wrap = prev_ok && (q_in < q_prev).
- Every cycle: q_prev<=q_in, prev_ok<=1.
- prev_ok suppresses a false wrap on the first cycle after reset.
- Upstream counter held in its own reset (q_in stuck at 0) means no wrap.
- Non-consecutive jumps count as a wrap only if q_in decreases.

wrap_pulse:
- Registered: asserted the cycle after the edge where wrap is true, for exactly one cycle.

Handshake FSM (two states):
- IDLE: duty_ready=1.
  - duty_valid&&duty_ready: capture pending<=duty_in, go to PEND.
- PEND: duty_ready=0; duty_valid is ignored.
  - On wrap: active<=pending, go to IDLE (duty_ready=1 next cycle).
- Accept in IDLE on the same edge as a wrap: the value goes to pending only and is applied at the following wrap, not the current one.

PWM output:
- pwm_out <= (q_in < active_duty), latency 1 cycle from q_in.
- Compare is unsigned, CW bits.
- duty 0: constantly low.
- duty 31: high for 31 of 32 counts.
- There is no 100% setting.
- Edge where active_duty updates: the compare uses the old active value; the new value takes effect on the next edge.

period_tally:
- On wrap, increments by 1, saturating at 2**PW-1.
- tally_clr has priority over increment.
- tally_clr and wrap on the same edge: result is 0.

Reset mid-operation:
- Asynchronous assertion clears all state at once, including pending duty.
- Deassertion needs no re-handshake; the FSM returns to IDLE.

Decomposition:
- Shared package holds:
  - CW and PW defaults.
  - Handshake state enum {IDLE, PEND}.
  - Constant TALLY_MAX = 2**PW-1.
- One natural sub-module: count_wrap_detect.
  - Contains q_prev, prev_ok and the wrap compare.
  - Outputs combinational wrap.
- FSM, PWM compare and tally stay in the top module.

Test Plan:
1. Hold reset 1 for 30 time units while the counter is also in reset -> all outputs at reset values; no wrap_pulse after release while q_in stays 0.
2. Load duty 8 in IDLE, counter free-running 0..31 -> duty_ready low until the first wrap. In the next period, pwm_out is high for exactly 8 cycles, starting one cycle after q_in=0.
3. Offer duty 20 while in PEND -> no capture; duty_ready stays 0. After the wrap, a re-offered 20 is accepted and applied at the following wrap.
4. duty_valid with duty 5 on the same edge as the 31->0 wrap, FSM in IDLE -> the current period still uses the old duty; 5 takes effect at the next wrap.
5. Duty 0 and duty 31 -> pwm_out is 0 for all 32 counts, and 1 for 31 counts / 0 for 1 count (q_in=31), respectively.
6. Run 260 wraps with PW=8 -> period_tally saturates at 255. Assert tally_clr together with a wrap -> period_tally=0. Assert reset mid-period -> pwm_out falls asynchronously and pending duty is discarded.

Source files
------------

// File: rtl/count_pwm_stage_pkg.sv
// Shared defaults, handshake state type and tally limit for the count-to-PWM stage.
package count_pwm_stage_pkg;

    localparam int CW_DEF = 5;
    localparam int PW_DEF = 8;

    localparam logic [PW_DEF-1:0] TALLY_MAX = {PW_DEF{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } hs_state_e;

endpackage

// File: rtl/count_wrap_detect.sv
// Detects the upstream counter rolling over by watching for a decrease in its value.
module count_wrap_detect
    import count_pwm_stage_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] q_in,
    output logic          wrap
);

    logic [CW-1:0] q_prev_r;
    logic          prev_ok_r;

    // Remember last count; prev_ok_r blocks a bogus wrap on the first cycle out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_prev_r  <= {CW{1'b0}};
            prev_ok_r <= 1'b0;
        end else begin
            q_prev_r  <= q_in;
            prev_ok_r <= 1'b1;
        end
    end

    assign wrap = prev_ok_r && (q_in < q_prev_r);

endmodule

// File: rtl/count_pwm_stage.sv
// Turns a free-running count into a registered PWM with wrap-synchronised duty updates,
// a wrap pulse and a saturating period tally.
module count_pwm_stage
    import count_pwm_stage_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] q_in,
    input  logic [CW-1:0] duty_in,
    input  logic          duty_valid,
    output logic          duty_ready,
    input  logic          tally_clr,
    output logic          pwm_out,
    output logic          wrap_pulse,
    output logic [PW-1:0] period_tally
);

    localparam logic [PW-1:0] TALLY_SAT = {PW{1'b1}};

    hs_state_e     state_r;
    hs_state_e     state_nxt_s;
    logic [CW-1:0] pending_r;
    logic [CW-1:0] active_r;
    logic          capture_s;
    logic          apply_s;
    logic          wrap_s;

    count_wrap_detect #(.CW(CW)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .q_in  (q_in),
        .wrap  (wrap_s)
    );

    // Handshake next-state: capture in IDLE, promote pending to active on a wrap in PEND.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        apply_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (duty_valid && duty_ready) begin
                    capture_s   = 1'b1;
                    state_nxt_s = PEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PEND: begin
                if (wrap_s) begin
                    apply_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = PEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, duty double buffer and the registered ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            pending_r  <= {CW{1'b0}};
            active_r   <= {CW{1'b0}};
            duty_ready <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            duty_ready <= (state_nxt_s == IDLE);
            if (capture_s) begin
                pending_r <= duty_in;
            end
            if (apply_s) begin
                active_r <= pending_r;
            end
        end
    end

    // PWM compare uses the pre-update active duty, so a new duty starts one edge after the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out    <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            pwm_out    <= (q_in < active_r);
            wrap_pulse <= wrap_s;
        end
    end

    // Saturating wrap tally; clear wins over a coincident wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_tally <= {PW{1'b0}};
        end else if (tally_clr) begin
            period_tally <= {PW{1'b0}};
        end else if (wrap_s && (period_tally != TALLY_SAT)) begin
            period_tally <= period_tally + {{(PW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_count_pwm_stage.sv
// Self-checking bench for count_pwm_stage: cycle scoreboard against a reference model,
// duty vector table, and hand sequences for handshake, wrap-edge and reset corners.
module tb_count_pwm_stage;
    import count_pwm_stage_pkg::*;

    localparam int CW = 5;
    localparam int PW = 8;

    logic          clk;
    logic          reset;
    logic [CW-1:0] q_in;
    logic [CW-1:0] duty_in;
    logic          duty_valid;
    logic          duty_ready;
    logic          tally_clr;
    logic          pwm_out;
    logic          wrap_pulse;
    logic [PW-1:0] period_tally;

    count_pwm_stage #(.CW(CW), .PW(PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .q_in         (q_in),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .tally_clr    (tally_clr),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .period_tally (period_tally)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          pwm;
        logic          wrap;
        logic          ready;
        logic [PW-1:0] tally;
    } out_t;

    typedef struct {
        logic [CW-1:0] duty;
        int            exp_high;
    } vec_t;

    out_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state
    logic [CW-1:0] m_qprev;
    logic          m_prev_ok;
    logic          m_pend;
    logic [CW-1:0] m_pending;
    logic [CW-1:0] m_active;
    logic [PW-1:0] m_tally;

    logic [CW-1:0] cnt;
    logic          cnt_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_qprev   = '0;
        m_prev_ok = 1'b0;
        m_pend    = 1'b0;
        m_pending = '0;
        m_active  = '0;
        m_tally   = '0;
    endtask

    task automatic model_edge();
        out_t e;
        logic w;
        w       = m_prev_ok && (q_in < m_qprev);
        e.pwm   = (q_in < m_active);
        e.wrap  = w;
        if (!m_pend) begin
            if (duty_valid) begin
                m_pending = duty_in;
                m_pend    = 1'b1;
            end
        end else if (w) begin
            m_active = m_pending;
            m_pend   = 1'b0;
        end
        if (tally_clr) m_tally = '0;
        else if (w && m_tally != TALLY_MAX) m_tally = m_tally + 8'd1;
        m_qprev   = q_in;
        m_prev_ok = 1'b1;
        e.ready   = !m_pend;
        e.tally   = m_tally;
        sb_q.push_back(e);
    endtask

    // One clock: drive q_in, predict, clock, then compare the DUT against the scoreboard head.
    task automatic step();
        out_t e;
        q_in = cnt_hold ? 5'd0 : cnt;
        model_edge();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("pwm_out", {31'd0, pwm_out}, {31'd0, e.pwm});
            chk("wrap_pulse", {31'd0, wrap_pulse}, {31'd0, e.wrap});
            chk("duty_ready", {31'd0, duty_ready}, {31'd0, e.ready});
            chk("period_tally", {24'd0, period_tally}, {24'd0, e.tally});
        end
        if (!cnt_hold) cnt = cnt + 5'd1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        duty_valid = 1'b0;
        while (m_pend && n < 100) begin
            step();
            n++;
        end
        if (m_pend) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic align_to(input logic [CW-1:0] v);
        int n;
        n = 0;
        while (cnt != v && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic load_duty(input logic [CW-1:0] d);
        wait_idle();
        duty_in    = d;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        chk("ready_after_accept", {31'd0, duty_ready}, 32'd0);
        wait_idle();
    endtask

    task automatic measure(output int highs);
        highs = 0;
        align_to(5'd0);
        for (int i = 0; i < 32; i++) begin
            step();
            highs += int'(pwm_out);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        int   h;

        vecs[0] = '{duty: 5'd8,  exp_high: 8};
        vecs[1] = '{duty: 5'd0,  exp_high: 0};
        vecs[2] = '{duty: 5'd31, exp_high: 31};
        vecs[3] = '{duty: 5'd1,  exp_high: 1};
        vecs[4] = '{duty: 5'd17, exp_high: 17};

        reset      = 1'b1;
        q_in       = 5'd0;
        duty_in    = 5'd0;
        duty_valid = 1'b0;
        tally_clr  = 1'b0;
        cnt        = 5'd0;
        cnt_hold   = 1'b1;
        model_reset();

        // Reset held with the counter also stuck at zero.
        #30;
        chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
        chk("rst_wrap", {31'd0, wrap_pulse}, 32'd0);
        chk("rst_ready", {31'd0, duty_ready}, 32'd1);
        chk("rst_tally", {24'd0, period_tally}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        cnt_hold = 1'b0;

        // Duty table: steady-state high count per period.
        foreach (vecs[i]) begin
            load_duty(vecs[i].duty);
            measure(h);
            chk("period_high", h, vecs[i].exp_high);
        end

        // Offer during PEND is ignored; re-offer after the wrap is taken.
        wait_idle();
        align_to(5'd2);
        duty_in = 5'd12; duty_valid = 1'b1;
        step();
        duty_in = 5'd20;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pend_ready_low", {31'd0, duty_ready}, 32'd0);
        end
        wait_idle();
        measure(h);
        chk("pend_ignored", h, 12);
        load_duty(5'd20);
        measure(h);
        chk("reoffer_applied", h, 20);

        // Accept on the wrap edge: current period keeps old duty (8), 5 applies one wrap later.
        load_duty(5'd8);
        align_to(5'd0);
        duty_in = 5'd5; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        chk("wrapedge_pend", {31'd0, duty_ready}, 32'd0);
        h = 0;
        for (int i = 0; i < 31; i++) begin
            step();
            h += int'(pwm_out);
        end
        chk("wrapedge_old_duty", h, 7);
        measure(h);
        chk("wrapedge_new_duty", h, 5);

        // Tally saturation, then clear coinciding with a wrap.
        for (int i = 0; i < 260 * 32; i++) step();
        chk("tally_sat", {24'd0, period_tally}, {24'd0, TALLY_MAX});
        align_to(5'd0);
        tally_clr = 1'b1;
        step();
        tally_clr = 1'b0;
        chk("tally_clr_wrap", {24'd0, period_tally}, 32'd0);

        // Asynchronous reset mid-period discards a pending duty.
        load_duty(5'd31);
        align_to(5'd3);
        duty_in = 5'd10; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        step();
        chk("pre_reset_pwm", {31'd0, pwm_out}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_pwm_low", {31'd0, pwm_out}, 32'd0);
        chk("async_ready", {31'd0, duty_ready}, 32'd1);
        chk("async_tally", {24'd0, period_tally}, 32'd0);
        model_reset();
        #3;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) step();
        measure(h);
        chk("pending_discarded", h, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
